// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ requesters, one burst per grant.
// Define FIFO_WR_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int BYTE_WIDTH = 1,
  parameter int BURST_LEN  = 16,
  localparam int DW  = BYTE_WIDTH * 8,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(BURST_LEN + 1)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  wr_full,
  output logic                  wr_en,
  output logic [DW-1:0]         wr_data,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] grant_nxt;
  logic [IDW-1:0] winner;
  logic           winner_found;
  logic [CW-1:0]  beat_cnt, beat_nxt;
  logic           burst_done;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        winner       = IDW'(i);
        winner_found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] cand;
  int             idx;

  // Scan from farthest to nearest after last_grant so the nearest valid requester wins.
  always_comb begin
    idx          = 0;
    cand         = '0;
    winner       = '0;
    winner_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (req_valid[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (state == XFER && burst_done) begin
      last_grant <= grant_id;
    end
  end
`endif

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Outputs are gated by the registered state, so an async reset silences them at once.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    beat_nxt   = beat_cnt;
    req_ready  = '0;
    wr_en      = 1'b0;
    wr_data    = '0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (winner_found) begin
          state_nxt = XFER;
          grant_nxt = winner;
          beat_nxt  = '0;
        end
      end
      XFER: begin
        req_ready[grant_id] = ~wr_full;
        wr_en               = req_valid[grant_id] & ~wr_full;
        wr_data             = req_data[grant_id*DW +: DW];
        if (wr_en) beat_nxt = beat_cnt + 1'b1;
        burst_done = ~req_valid[grant_id] |
                     (wr_en & (req_last[grant_id] | (beat_nxt == CW'(BURST_LEN))));
        if (burst_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_valid = (state == XFER);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized traffic,
// all compared each cycle against a behavioural grant/burst model.
module tb_fifo_wr_arb;

  localparam int NUM_REQ    = 4;
  localparam int BYTE_WIDTH = 1;
  localparam int BURST_LEN  = 4;
  localparam int DW         = BYTE_WIDTH * 8;
  localparam int IDW        = 2;
  localparam int OW         = 1 + IDW + 1 + NUM_REQ + DW;

  logic                  wr_clk;
  logic                  wr_rstn;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  wr_full;
  logic                  wr_en;
  logic [DW-1:0]         wr_data;
  logic                  grant_valid;
  logic [IDW-1:0]        grant_id;
  logic [OW-1:0]         obs;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arb #(
    .NUM_REQ   (NUM_REQ),
    .BYTE_WIDTH(BYTE_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rstn    (wr_rstn),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_full    (wr_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign obs = {grant_valid, grant_id, wr_en, req_ready, wr_data};

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // Behavioural model: who holds the grant, how many beats it has taken, who went last.
  logic           m_busy = 1'b0;
  logic [IDW-1:0] m_gid  = '0;
  int             m_last = NUM_REQ - 1;
  int             m_cnt  = 0;

  function automatic logic [IDW-1:0] pick_winner();
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++)
      if (req_valid[k]) return IDW'(k);
`else
    for (int k = 1; k <= NUM_REQ; k++)
      if (req_valid[(m_last + k) % NUM_REQ]) return IDW'((m_last + k) % NUM_REQ);
`endif
    return '0;
  endfunction

  always @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      m_busy = 1'b0;
      m_gid  = '0;
      m_last = NUM_REQ - 1;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (req_valid != '0) begin
        m_gid  = pick_winner();
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!req_valid[m_gid]) begin
      m_busy = 1'b0;
      m_last = int'(m_gid);
    end else if (!wr_full) begin
      m_cnt = m_cnt + 1;
      if (req_last[m_gid] || m_cnt == BURST_LEN) begin
        m_busy = 1'b0;
        m_last = int'(m_gid);
      end
    end
  end

  function automatic logic [OW-1:0] model_exp();
    logic [NUM_REQ-1:0] rdy;
    logic               we;
    logic [DW-1:0]      d;
    rdy = '0;
    we  = 1'b0;
    d   = '0;
    if (m_busy && wr_rstn) begin
      rdy[m_gid] = ~wr_full;
      we         = req_valid[m_gid] & ~wr_full;
      d          = req_data[m_gid*DW +: DW];
    end
    return {m_busy & wr_rstn, m_gid, we, rdy, d};
  endfunction

  // Requester sources: packets of src_len beats, data encodes requester and beat index.
  logic [NUM_REQ-1:0] src_on;
  int src_len  [NUM_REQ];
  int src_sent [NUM_REQ];
  int src_pkts [NUM_REQ];

  task automatic set_src(input int i, input logic on, input int len, input int pkts);
    src_on[i]   = on;
    src_len[i]  = len;
    src_sent[i] = 0;
    src_pkts[i] = pkts;
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]          = src_on[i] && (src_pkts[i] > 0);
      req_last[i]           = (src_sent[i] == src_len[i] - 1);
      req_data[i*DW +: DW]  = DW'((i << 5) | (src_sent[i] & 31));
    end
  endtask

  task automatic next_cycle(input logic [NUM_REQ-1:0] acc);
    @(posedge wr_clk);
    @(negedge wr_clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        src_sent[i] = src_sent[i] + 1;
        if (src_sent[i] == src_len[i]) begin
          src_sent[i] = 0;
          src_pkts[i] = src_pkts[i] - 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    wr_rstn   = 1'b1;
    #1;
    wr_rstn   = 1'b0;
    wr_full   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b0, 1, 0);
    @(posedge wr_clk);
    @(negedge wr_clk);
    wr_rstn = 1'b1;
  endtask

  task automatic test_reset();
    wr_rstn = 1'b1;
    #1;
    wr_rstn   = 1'b0;
    wr_full   = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = $urandom;
    @(posedge wr_clk);
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", obs, {OW{1'b0}});
    end
    @(negedge wr_clk);
    req_valid = '0;
    wr_rstn   = 1'b1;
    #2;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_release_idle got=%h exp=%h", obs, {OW{1'b0}});
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] acc;
    logic               exp_gv;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b1, 1, 100);
    for (int c = 0; c <= 10; c++) begin
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL rr_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      exp_gv = (c % 2 == 1);
      checks++;
      if (grant_valid !== exp_gv || wr_en !== exp_gv ||
          (exp_gv && grant_id !== IDW'(((c - 1) / 2) % NUM_REQ))) begin
        failures++;
        $display("[TB] FAIL rr_sequence c=%0d got gv=%b id=%0d en=%b exp gv=%b id=%0d",
                 c, grant_valid, grant_id, wr_en, exp_gv, ((c - 1) / 2) % NUM_REQ);
      end
      acc = req_valid & req_ready;
      next_cycle(acc);
    end
  endtask

  task automatic test_burst_split();
    logic [NUM_REQ-1:0] acc;
    logic prev_gv = 1'b0;
    int   gq[$];
    int   bq[$];
    int   exp_g[5] = '{2, 1, 2, 1, 2};
    int   exp_b[3] = '{4, 4, 2};
    do_reset();
    set_src(2, 1'b1, 10, 1);
    for (int c = 0; c < 40; c++) begin
      if (c == 2) set_src(1, 1'b1, 1, 100);
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL split_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      if (grant_valid && !prev_gv) begin
        gq.push_back(int'(grant_id));
        if (grant_id == 2) bq.push_back(0);
      end
      prev_gv = grant_valid;
      acc = req_valid & req_ready;
      if (acc[2] && bq.size() > 0) bq[bq.size() - 1] = bq[bq.size() - 1] + 1;
      next_cycle(acc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= gq.size() || gq[i] != exp_g[i]) begin
        failures++;
        $display("[TB] FAIL split_grant_order idx=%0d got=%0d exp=%0d",
                 i, (i < gq.size()) ? gq[i] : -1, exp_g[i]);
      end
    end
    checks++;
    if (bq.size() != 3) begin
      failures++;
      $display("[TB] FAIL split_grant_count got=%0d exp=3", bq.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= bq.size() || bq[i] != exp_b[i]) begin
        failures++;
        $display("[TB] FAIL split_beats idx=%0d got=%0d exp=%0d",
                 i, (i < bq.size()) ? bq[i] : -1, exp_b[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    logic [NUM_REQ-1:0] acc;
    do_reset();
    set_src(0, 1'b1, 8, 1);
    for (int c = 0; c <= 12; c++) begin
      wr_full = (c >= 3 && c <= 7);
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL stall_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      if (c >= 3 && c <= 7) begin
        checks++;
        if (wr_en !== 1'b0 || req_ready !== '0 || grant_valid !== 1'b1 || grant_id !== '0) begin
          failures++;
          $display("[TB] FAIL stall_hold c=%0d got en=%b rdy=%b gv=%b id=%0d exp en=0 rdy=0 gv=1 id=0",
                   c, wr_en, req_ready, grant_valid, grant_id);
        end
      end
      if (c == 8) begin
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 8'd2) begin
          failures++;
          $display("[TB] FAIL stall_resume got en=%b data=%h exp en=1 data=02", wr_en, wr_data);
        end
      end
      if (c == 10) begin
        checks++;
        if (grant_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stall_burst_end got gv=%b exp gv=0", grant_valid);
        end
      end
      if (c == 11) begin
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== '0) begin
          failures++;
          $display("[TB] FAIL stall_regrant got gv=%b id=%0d exp gv=1 id=0", grant_valid, grant_id);
        end
      end
      acc = req_valid & req_ready;
      next_cycle(acc);
    end
    wr_full = 1'b0;
  endtask

  task automatic test_drop_valid();
    logic [NUM_REQ-1:0] acc;
    do_reset();
    set_src(0, 1'b1, 8, 1);
    set_src(1, 1'b1, 1, 1);
    for (int c = 0; c <= 7; c++) begin
      if (src_sent[0] == 2) src_on[0] = 1'b0;
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL drop_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      if (c == 3) begin
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0 || wr_en !== 1'b0) begin
          failures++;
          $display("[TB] FAIL drop_last_xfer got gv=%b id=%0d en=%b exp gv=1 id=0 en=0",
                   grant_valid, grant_id, wr_en);
        end
      end
      if (c == 4) begin
        checks++;
        if (grant_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL drop_bubble got gv=%b exp gv=0", grant_valid);
        end
      end
      if (c == 5) begin
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
          failures++;
          $display("[TB] FAIL drop_next_grant got gv=%b id=%0d exp gv=1 id=1", grant_valid, grant_id);
        end
      end
      acc = req_valid & req_ready;
      next_cycle(acc);
    end
  endtask

  task automatic test_async_reset();
    logic [NUM_REQ-1:0] acc;
    do_reset();
    set_src(1, 1'b1, 8, 1);
    for (int c = 0; c <= 1; c++) begin
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL arst_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      acc = req_valid & req_ready;
      next_cycle(acc);
    end
    drive_sources();
    #2;
    checks++;
    if (wr_en !== 1'b1 || grant_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arst_midbeat got en=%b gv=%b exp en=1 gv=1", wr_en, grant_valid);
    end
    #1;
    wr_rstn = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || req_ready !== '0 || grant_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_immediate got en=%b rdy=%b gv=%b exp en=0 rdy=0 gv=0",
               wr_en, req_ready, grant_valid);
    end
    @(negedge wr_clk);
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b1, 1, 10);
    wr_rstn = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL arst_after_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      if (c == 1) begin
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
          failures++;
          $display("[TB] FAIL arst_first_winner got gv=%b id=%0d exp gv=1 id=0", grant_valid, grant_id);
        end
      end
      acc = req_valid & req_ready;
      next_cycle(acc);
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] acc;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_pkts[i] == 0) begin
          if ($urandom_range(0, 7) == 0) set_src(i, 1'b1, int'($urandom_range(1, 7)), 1);
        end else if (src_on[i]) begin
          if ($urandom_range(0, 19) == 0) src_on[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          src_on[i] = 1'b1;
        end
      end
      wr_full = ($urandom_range(0, 3) == 0);
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL rand_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      acc = req_valid & req_ready;
      next_cycle(acc);
    end
    wr_full = 1'b0;
  endtask

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    logic [NUM_REQ-1:0] acc;
    do_reset();
    set_src(0, 1'b1, 1, 100);
    set_src(2, 1'b1, 1, 100);
    for (int c = 0; c < 20; c++) begin
      drive_sources();
      #2;
      checks++;
      if (obs !== model_exp()) begin
        failures++;
        $display("[TB] FAIL fixed_model c=%0d got=%h exp=%h", c, obs, model_exp());
      end
      checks++;
      if (grant_valid === 1'b1 && grant_id !== 2'd0) begin
        failures++;
        $display("[TB] FAIL fixed_winner c=%0d got id=%0d exp id=0", c, grant_id);
      end
      acc = req_valid & req_ready;
      next_cycle(acc);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wr_rstn   = 1'b1;
    wr_full   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    test_reset();
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    test_fixed_prio();
    test_full_stall();
`else
    test_round_robin();
    test_burst_split();
    test_full_stall();
    test_drop_valid();
    test_async_reset();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
